toy_bpu_ras: RTL and testbench

TOY_BPU_RAS -- requirements
Module: toy_bpu_ras

---
 rtl/toy_bpu_ras.sv | 141 ++++++++++++++
 tb/tb_toy_bpu_ras.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bpu_ras.sv
// Return-address stack for a toy branch predictor: a speculative stack feeding
// predictions and a committed stack that restores it on backend redirects.
package toy_pack;
  localparam int unsigned ADDR_WIDTH = 32;

  typedef struct packed {
    logic [1:0]            inst_type;  // {is_ret, is_call}
    logic [ADDR_WIDTH-1:0] pc;
    logic                  is_cext;
  } ras_pkg;
endpackage

module toy_bpu_ras #(
  parameter int unsigned RAS_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = toy_pack::ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ras_req_vld,
  input  toy_pack::ras_pkg             ras_req_pld,
  output logic                         ras_ack_vld,
  output logic [ADDR_WIDTH-1:0]        ras_ack_pld,
  input  logic                         cmt_vld,
  input  logic [1:0]                   cmt_inst_type,
  input  logic [ADDR_WIDTH-1:0]        cmt_pc,
  input  logic                         cmt_is_cext,
  input  logic                         be_chgflw_vld,
  output logic [$clog2(RAS_DEPTH):0]   ras_cnt
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic          we;
    logic [PW-1:0] widx;
    logic [PW-1:0] top;
    logic [CW-1:0] cnt;
  } upd_t;

  addr_t         spec_mem [RAS_DEPTH];
  addr_t         cmt_mem  [RAS_DEPTH];
  logic [PW-1:0] spec_top;
  logic [PW-1:0] cmt_top;
  logic [CW-1:0] spec_cnt;
  logic [CW-1:0] cmt_cnt;

  upd_t  spec_u;
  upd_t  cmt_u;
  addr_t spec_wdata;
  addr_t cmt_wdata;

  // Next pointer/count and write slot for one stack given {is_ret,is_call}.
  function automatic upd_t stack_upd(input logic [1:0]    op,
                                     input logic [PW-1:0] top,
                                     input logic [CW-1:0] cnt);
    upd_t u;
    u.we   = 1'b0;
    u.widx = top;
    u.top  = top;
    u.cnt  = cnt;
    case (op)
      2'b01: begin
        u.we   = 1'b1;
        u.widx = top + PW'(1);
        u.top  = top + PW'(1);
        if (cnt != CW'(RAS_DEPTH)) u.cnt = cnt + CW'(1);
      end
      2'b10: begin
        if (cnt != '0) begin
          u.top = top - PW'(1);
          u.cnt = cnt - CW'(1);
        end
      end
      2'b11: begin
        // An empty stack has no top entry to replace, so fall back to a push.
        if (cnt == '0) begin
          u.we   = 1'b1;
          u.widx = top + PW'(1);
          u.top  = top + PW'(1);
          u.cnt  = CW'(1);
        end else begin
          u.we   = 1'b1;
          u.widx = top;
        end
      end
      default: ;
    endcase
    return u;
  endfunction

  function automatic addr_t ret_addr(input addr_t pc, input logic is_cext);
    return pc + (is_cext ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
  endfunction

  always_comb begin
    cmt_u      = stack_upd(cmt_vld ? cmt_inst_type : 2'b00, cmt_top, cmt_cnt);
    cmt_wdata  = ret_addr(cmt_pc, cmt_is_cext);
    spec_u     = stack_upd(ras_req_vld ? ras_req_pld.inst_type : 2'b00, spec_top, spec_cnt);
    spec_wdata = ret_addr(ADDR_WIDTH'(ras_req_pld.pc), ras_req_pld.is_cext);
  end

  // Pointers and counts; a redirect copies the committed next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_top <= '0;
      spec_cnt <= '0;
      cmt_top  <= '0;
      cmt_cnt  <= '0;
    end else begin
      cmt_top <= cmt_u.top;
      cmt_cnt <= cmt_u.cnt;
      if (be_chgflw_vld) begin
        spec_top <= cmt_u.top;
        spec_cnt <= cmt_u.cnt;
      end else begin
        spec_top <= spec_u.top;
        spec_cnt <= spec_u.cnt;
      end
    end
  end

  // Entry storage is unreset; validity is tracked by the counts alone.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
      if (cmt_u.we && (cmt_u.widx == PW'(i))) cmt_mem[i] <= cmt_wdata;
      if (be_chgflw_vld) begin
        spec_mem[i] <= (cmt_u.we && (cmt_u.widx == PW'(i))) ? cmt_wdata : cmt_mem[i];
      end else if (spec_u.we && (spec_u.widx == PW'(i))) begin
        spec_mem[i] <= spec_wdata;
      end
    end
  end

  assign ras_ack_vld = (spec_cnt != '0);
  assign ras_ack_pld = spec_mem[spec_top];
  assign ras_cnt     = spec_cnt;

endmodule

// File: tb/tb_toy_bpu_ras.sv
// Scoreboard bench for toy_bpu_ras: a queue-based stack model predicts each
// cycle's outputs, which are compared one cycle after the stimulus edge.
module tb_toy_bpu_ras;

  localparam int unsigned DEPTH = 8;

  typedef logic [31:0] aq_t[$];
  typedef struct {
    bit          vld;
    logic [31:0] pld;
    logic [3:0]  cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             ras_req_vld;
  toy_pack::ras_pkg ras_req_pld;
  logic             ras_ack_vld;
  logic [31:0]      ras_ack_pld;
  logic             cmt_vld;
  logic [1:0]       cmt_inst_type;
  logic [31:0]      cmt_pc;
  logic             cmt_is_cext;
  logic             be_chgflw_vld;
  logic [3:0]       ras_cnt;

  aq_t  m_spec;
  aq_t  m_cmt;
  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  toy_bpu_ras #(.RAS_DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ras_req_vld   (ras_req_vld),
    .ras_req_pld   (ras_req_pld),
    .ras_ack_vld   (ras_ack_vld),
    .ras_ack_pld   (ras_ack_pld),
    .cmt_vld       (cmt_vld),
    .cmt_inst_type (cmt_inst_type),
    .cmt_pc        (cmt_pc),
    .cmt_is_cext   (cmt_is_cext),
    .be_chgflw_vld (be_chgflw_vld),
    .ras_cnt       (ras_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ra(input logic [31:0] pc, input bit c);
    return c ? pc + 32'd2 : pc + 32'd4;
  endfunction

  function automatic aq_t apply(input aq_t q, input logic [1:0] op, input logic [31:0] a);
    aq_t r = q;
    case (op)
      2'b01: begin
        r.push_back(a);
        if (r.size() > DEPTH) void'(r.pop_front());
      end
      2'b10: if (r.size() > 0) void'(r.pop_back());
      2'b11: if (r.size() == 0) r.push_back(a); else r[r.size()-1] = a;
      default: ;
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; ras_req_vld = 1'b0; ras_req_pld = '0;
    cmt_vld = 1'b0; cmt_inst_type = 2'b00; cmt_pc = '0; cmt_is_cext = 1'b0;
    be_chgflw_vld = 1'b0;
  endtask

  // Drive one cycle, advance the model, queue the expected outputs.
  task automatic drive(input bit r, input bit rv, input logic [1:0] rt, input logic [31:0] rpc,
                       input bit rc, input bit cv, input logic [1:0] ct, input logic [31:0] cpc,
                       input bit cc, input bit chg);
    exp_t x;
    rst = r; ras_req_vld = rv;
    ras_req_pld.inst_type = rt; ras_req_pld.pc = rpc; ras_req_pld.is_cext = rc;
    cmt_vld = cv; cmt_inst_type = ct; cmt_pc = cpc; cmt_is_cext = cc;
    be_chgflw_vld = chg;
    if (r) begin
      m_spec.delete();
      m_cmt.delete();
    end else begin
      if (cv) m_cmt = apply(m_cmt, ct, ra(cpc, cc));
      if (chg) m_spec = m_cmt;
      else if (rv) m_spec = apply(m_spec, rt, ra(rpc, rc));
    end
    x.vld = (m_spec.size() != 0);
    x.cnt = 4'(m_spec.size());
    x.pld = x.vld ? m_spec[m_spec.size()-1] : 32'h0;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic req(input logic [1:0] op, input logic [31:0] pc, input bit c);
    drive(0, 1, op, pc, c, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
    e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    drive(1, 1, 2'b01, 32'h40, 0, 1, 2'b01, 32'h80, 0, 0);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b0 || ras_cnt !== 4'd0 || e.cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: vld=%b cnt=%0d, required vld=0 cnt=0", ras_ack_vld, ras_cnt);
    end
  endtask

  task automatic test_push_pop();
    req(2'b01, 32'h1000, 0);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b1 || ras_ack_pld !== 32'h1004 || ras_cnt !== 4'd1 ||
        ras_ack_pld !== e.pld) begin
      n_fail++;
      $display("FAIL push: vld=%b pld=%h cnt=%0d, required vld=1 pld=00001004 cnt=1",
               ras_ack_vld, ras_ack_pld, ras_cnt);
    end
    req(2'b10, 32'h1000, 0);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b0 || ras_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL pop: vld=%b cnt=%0d, required vld=0 cnt=0", ras_ack_vld, ras_cnt);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      req(2'b01, 32'(k) * 32'h100, 1);
      e = sb_q.pop_front();
      n_checks++;
      if (ras_ack_vld !== e.vld || ras_cnt !== e.cnt || ras_ack_pld !== e.pld) begin
        n_fail++;
        $display("FAIL overflow_push%0d: pld=%h cnt=%0d, required pld=%h cnt=%0d",
                 k, ras_ack_pld, ras_cnt, e.pld, e.cnt);
      end
    end
    n_checks++;
    if (ras_cnt !== 4'd8 || ras_ack_pld !== 32'h902) begin
      n_fail++;
      $display("FAIL overflow_full: pld=%h cnt=%0d, required pld=00000902 cnt=8", ras_ack_pld, ras_cnt);
    end
    for (int k = 9; k >= 2; k--) begin
      n_checks++;
      if (ras_ack_vld !== 1'b1 || ras_ack_pld !== 32'(k) * 32'h100 + 32'h2) begin
        n_fail++;
        $display("FAIL overflow_top%0d: vld=%b pld=%h, required pld=%h",
                 k, ras_ack_vld, ras_ack_pld, 32'(k) * 32'h100 + 32'h2);
      end
      req(2'b10, 32'h0, 0);
      e = sb_q.pop_front();
    end
    n_checks++;
    if (ras_ack_vld !== 1'b0 || ras_cnt !== 4'd0 || e.cnt !== ras_cnt) begin
      n_fail++;
      $display("FAIL overflow_empty: vld=%b cnt=%0d, required vld=0 cnt=0", ras_ack_vld, ras_cnt);
    end
    req(2'b10, 32'h0, 0);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b0 || ras_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL underflow_pop: vld=%b cnt=%0d, required vld=0 cnt=0", ras_ack_vld, ras_cnt);
    end
    // After an underflow attempt the pointer must still be usable.
    req(2'b01, 32'hA00, 0);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_pld !== 32'hA04 || ras_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL push_after_underflow: pld=%h cnt=%0d, required pld=00000a04 cnt=1", ras_ack_pld, ras_cnt);
    end
  endtask

  task automatic test_poppush();
    do_reset();
    req(2'b01, 32'h1000, 0);
    e = sb_q.pop_front();
    req(2'b11, 32'h2000, 1);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_pld !== 32'h2002 || ras_cnt !== 4'd1 || ras_ack_pld !== e.pld) begin
      n_fail++;
      $display("FAIL poppush: pld=%h cnt=%0d, required pld=00002002 cnt=1", ras_ack_pld, ras_cnt);
    end
    req(2'b10, 32'h0, 0);
    e = sb_q.pop_front();
    req(2'b11, 32'h2100, 0);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b1 || ras_cnt !== 4'd1 || ras_ack_pld !== 32'h2104) begin
      n_fail++;
      $display("FAIL poppush_empty: vld=%b pld=%h cnt=%0d, required vld=1 pld=00002104 cnt=1",
               ras_ack_vld, ras_ack_pld, ras_cnt);
    end
  endtask

  task automatic test_chgflw_restore();
    do_reset();
    drive(0, 1, 2'b01, 32'h3000, 0, 1, 2'b01, 32'h3000, 0, 0);
    e = sb_q.pop_front();
    req(2'b01, 32'h4000, 0);
    e = sb_q.pop_front();
    req(2'b10, 32'h0, 0);
    e = sb_q.pop_front();
    req(2'b10, 32'h0, 0);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b0 || ras_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL chgflw_pre: vld=%b cnt=%0d, required vld=0 cnt=0", ras_ack_vld, ras_cnt);
    end
    drive(0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b1 || ras_ack_pld !== 32'h3004 || ras_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL chgflw_restore: vld=%b pld=%h cnt=%0d, required vld=1 pld=00003004 cnt=1",
               ras_ack_vld, ras_ack_pld, ras_cnt);
    end
  endtask

  task automatic test_chgflw_priority();
    do_reset();
    drive(0, 1, 2'b01, 32'h5000, 0, 1, 2'b01, 32'h6000, 0, 1);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_pld !== 32'h6004 || ras_cnt !== 4'd1 || ras_ack_pld !== e.pld) begin
      n_fail++;
      $display("FAIL chgflw_priority: pld=%h cnt=%0d, required pld=00006004 cnt=1", ras_ack_pld, ras_cnt);
    end
    req(2'b10, 32'h0, 0);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b0 || ras_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL chgflw_dropped_req: vld=%b cnt=%0d, required vld=0 cnt=0", ras_ack_vld, ras_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 2'b01, 32'h7000 + 32'(k) * 32'h10, 0, 1, 2'b01, 32'h8000 + 32'(k) * 32'h10, 1, 0);
      e = sb_q.pop_front();
    end
    drive(1, 1, 2'b01, 32'h7100, 0, 1, 2'b01, 32'h8100, 0, 1);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b0 || ras_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: vld=%b cnt=%0d, required vld=0 cnt=0", ras_ack_vld, ras_cnt);
    end
    drive(0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
    e = sb_q.pop_front();
    n_checks++;
    if (ras_ack_vld !== 1'b0 || ras_cnt !== 4'd0 || ras_cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL reset_then_chgflw: vld=%b cnt=%0d, required vld=0 cnt=0", ras_ack_vld, ras_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
            $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0);
      e = sb_q.pop_front();
      n_checks++;
      if (ras_ack_vld !== e.vld || ras_cnt !== e.cnt || (e.vld && ras_ack_pld !== e.pld)) begin
        n_fail++;
        $display("FAIL random%0d: vld=%b pld=%h cnt=%0d, required vld=%b pld=%h cnt=%0d",
                 n, ras_ack_vld, ras_ack_pld, ras_cnt, e.vld, e.pld, e.cnt);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_poppush();
    test_chgflw_restore();
    test_chgflw_priority();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
